// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU operation dispatcher.
// FSM state encoding, unit opcode constants and default widths.
package alu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitHi,
    StWaitLo,
    StOut
  } alu_state_e;

  localparam logic [1:0] OP_COMPLEMENTO = 2'd0;
  localparam logic [1:0] OP_UNIT_1      = 2'd1;
  localparam logic [1:0] OP_UNIT_2      = 2'd2;
  localparam logic [1:0] OP_UNIT_3      = 2'd3;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_RES_W       = 4;
  localparam int unsigned DEF_NUM_OPS     = 4;
  localparam int unsigned DEF_OPCODE_W    = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 32;

endpackage

// File: rtl/alu_done_sync.sv
// Two-flop synchroniser for the per-unit done lines, which are not clk-synchronous.
module alu_done_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] done_async,
  output logic [WIDTH-1:0] done_s
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= done_async;
      sync_q <= meta_q;
    end
  end

  assign done_s = sync_q;

endmodule

// File: rtl/alu_op_dispatch.sv
// Dispatches one opcode/operand to an ALU unit over a 4-phase enable/done handshake.
// Optional per-phase timeout enabled by defining ALU_DISPATCH_TIMEOUT_EN.
module alu_op_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RES_W       = DEF_RES_W,
  parameter int unsigned NUM_OPS     = DEF_NUM_OPS,
  parameter int unsigned OPCODE_W    = DEF_OPCODE_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_W-1:0]      in_opcode,
  input  logic [DATA_W-1:0]        in_data,
  output logic [DATA_W-1:0]        op_data,
  output logic [NUM_OPS-1:0]       op_enable,
  input  logic [NUM_OPS-1:0]       op_done,
  input  logic [NUM_OPS*RES_W-1:0] op_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_result,
  output logic [OPCODE_W-1:0]      out_opcode,
  output logic                     out_err
);

  alu_state_e          state_q;
  logic [DATA_W-1:0]   op_data_q;
  logic [NUM_OPS-1:0]  op_enable_q;
  logic [NUM_OPS-1:0]  sel_q;
  logic                stale_q;
  logic [RES_W-1:0]    out_result_q;
  logic [OPCODE_W-1:0] out_opcode_q;
  logic                out_err_q;

  logic [NUM_OPS-1:0]  done_s;
  logic [NUM_OPS-1:0]  req_sel;
  logic                req_illegal;
  logic                sel_done;
  logic [RES_W-1:0]    sel_result;

  alu_done_sync #(
    .WIDTH(NUM_OPS)
  ) u_done_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .done_async(op_done),
    .done_s    (done_s)
  );

  always_comb begin
    req_sel    = '0;
    sel_result = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      if (32'(in_opcode) == i) req_sel[i] = 1'b1;
      if (sel_q[i]) sel_result = op_result[i*RES_W +: RES_W];
    end
  end

  assign req_illegal = 32'(in_opcode) >= NUM_OPS;
  assign sel_done    = |(done_s & sel_q);

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_data_q    <= '0;
      op_enable_q  <= '0;
      sel_q        <= '0;
      stale_q      <= 1'b0;
      out_result_q <= '0;
      out_opcode_q <= '0;
      out_err_q    <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_data_q    <= in_data;
            out_opcode_q <= in_opcode;
            sel_q        <= req_sel;
            // A done already high before launch must be seen low before it is trusted.
            stale_q      <= |(done_s & req_sel);
            out_result_q <= '0;
            out_err_q    <= req_illegal;
            state_q      <= req_illegal ? StOut : StLaunch;
          end
        end
        StLaunch: begin
          op_enable_q <= sel_q;
          if (!sel_done) stale_q <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          tmo_q       <= '0;
`endif
          state_q     <= StWaitHi;
        end
        StWaitHi: begin
          if (!stale_q && sel_done) begin
            out_result_q <= sel_result;
            op_enable_q  <= '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            tmo_q        <= '0;
`endif
            state_q      <= StWaitLo;
          end else begin
            if (!sel_done) stale_q <= 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            if (tmo_hit) begin
              op_enable_q <= '0;
              out_err_q   <= 1'b1;
              tmo_q       <= '0;
              state_q     <= StWaitLo;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
`endif
          end
        end
        StWaitLo: begin
          if (!sel_done) begin
            state_q <= StOut;
`ifdef ALU_DISPATCH_TIMEOUT_EN
          end else if (tmo_hit) begin
            out_err_q <= 1'b1;
            state_q   <= StOut;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        StOut: begin
          if (out_err_q) out_result_q <= '0;
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StOut);
  assign op_data    = op_data_q;
  assign op_enable  = op_enable_q;
  assign out_result = out_err_q ? '0 : out_result_q;
  assign out_opcode = out_opcode_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Self-checking bench for alu_op_dispatch with three attached unit models.
module tb_alu_op_dispatch;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned NO = 3;
  localparam int unsigned OW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_opcode;
  logic [DW-1:0] in_data;
  logic [DW-1:0] op_data;
  logic [NO-1:0] op_enable;
  logic [NO-1:0] op_done;
  logic [NO*RW-1:0] op_result;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic [OW-1:0] out_opcode;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  // Unit models: inst = done follows enable combinationally, otherwise after dly cycles.
  logic [NO-1:0] inst = '0;
  logic [NO-1:0] hang = '0;
  logic [NO-1:0] stuck = '0;
  logic [NO-1:0] noise = '0;
  logic          noise_en = 1'b0;
  logic [NO-1:0] done_q = '0;
  int            dly[NO];
  int            cnt[NO];
  int            en_count = 0;
  int            ov_count = 0;

  always #5 clk = ~clk;

  alu_op_dispatch #(
    .DATA_W     (DW),
    .RES_W      (RW),
    .NUM_OPS    (NO),
    .OPCODE_W   (OW),
    .TIMEOUT_CYC(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_data   (in_data),
    .op_data   (op_data),
    .op_enable (op_enable),
    .op_done   (op_done),
    .op_result (op_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_opcode(out_opcode),
    .out_err   (out_err)
  );

  function automatic logic [RW-1:0] unit_fn(input int op, input logic [DW-1:0] d);
    case (op)
      0:       return d[3:0];
      1:       return d[7:4];
      default: return d[3:0] ^ d[7:4];
    endcase
  endfunction

  function automatic logic [RW-1:0] exp_result(input int op, input logic [DW-1:0] d);
    return (op >= int'(NO)) ? 4'h0 : unit_fn(op, d);
  endfunction

  always_comb begin
    op_done = ((inst & op_enable) | (~inst & done_q)) | noise | stuck;
    op_result = '0;
    for (int i = 0; i < int'(NO); i++) op_result[i*RW +: RW] = unit_fn(i, op_data);
  end

  always @(posedge clk) begin
    for (int i = 0; i < int'(NO); i++) begin
      if (hang[i]) cnt[i] <= 0;
      else if (done_q[i] != op_enable[i]) begin
        if (cnt[i] >= dly[i]) begin
          done_q[i] <= op_enable[i];
          cnt[i]    <= 0;
        end else cnt[i] <= cnt[i] + 1;
      end else cnt[i] <= 0;
    end
    noise <= noise_en ? (noise ^ 3'b101) : 3'b000;
    if (|op_enable) en_count <= en_count + 1;
    if (out_valid) ov_count <= ov_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input int op, input logic [DW-1:0] d, input int hold, output int lat);
    int n;
    out_ready = 1'b0;
    in_opcode = op[OW-1:0];
    in_data   = d;
    in_valid  = 1'b1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out(300, n);
    lat = n + 1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_result", 32'(out_result), 32'(exp_result(op, d)));
    chk("out_opcode", 32'(out_opcode), 32'(op));
    chk("out_err", 32'(out_err), 32'(op >= int'(NO)));
    repeat (hold) step();
    chk("hold_stable", {out_valid, in_ready, out_err, out_opcode, out_result},
        {1'b1, 1'b0, 1'(op >= int'(NO)), op[OW-1:0], exp_result(op, d)});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int c0;
    int c1;
    int op;
    logic [DW-1:0] d;
    for (int i = 0; i < int'(NO); i++) dly[i] = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_opcode = '0;
    in_data = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", {op_enable, op_data, out_valid, out_result, out_opcode, out_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Instant unit: accept -> out_valid in cycle 8.
    inst = 3'b111;
    run_op(0, 8'hA5, 0, lat);
    chk("latency_legal", lat, 32'd8);

    // Illegal opcode: out_valid the next cycle, no enable.
    c0 = en_count;
    run_op(3, 8'h3C, 2, lat);
    chk("latency_illegal", lat, 32'd1);
    chk("illegal_no_enable", en_count, c0);

    // Backpressure: second request held off while the result waits.
    in_opcode = 2'd2;
    in_data = 8'h96;
    in_valid = 1'b1;
    step();
    in_opcode = 2'd1;
    in_data = 8'h7E;
    wait_out(300, n);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_stable", {out_valid, in_ready, out_err, out_opcode, out_result},
          {1'b1, 1'b0, 1'b0, 2'd2, unit_fn(2, 8'h96)});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_idle", {out_valid, in_ready}, 2'b01);
    step();
    in_valid = 1'b0;
    chk("bp_accept2", {in_ready, op_data}, {1'b0, 8'h7E});
    wait_out(300, n);
    chk("bp_result2", {out_valid, out_opcode, out_result}, {1'b1, 2'd1, 4'h7});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Done of non-selected units toggling is ignored.
    inst = 3'b000;
    dly[1] = 2;
    noise_en = 1'b1;
    run_op(1, 8'hC3, 1, lat);
    noise_en = 1'b0;
    step();

    // Stale done on the selected unit must be seen low first.
    hang[2] = 1'b1;
    stuck[2] = 1'b1;
    repeat (4) step();
    in_opcode = 2'd2;
    in_data = 8'h5A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("stale_hold", {op_enable, out_valid}, {3'b100, 1'b0});
    stuck[2] = 1'b0;
    repeat (6) step();
    chk("stale_still", {op_enable, out_valid}, {3'b100, 1'b0});
    hang[2] = 1'b0;
    wait_out(300, n);
    chk("stale_done", {out_valid, out_err, out_result}, {1'b1, 1'b0, unit_fn(2, 8'h5A)});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Randomised traffic against the reference model.
    for (int t = 0; t < 30; t++) begin
      op = int'($urandom_range(0, 3));
      d = DW'($urandom);
      inst = NO'($urandom);
      for (int i = 0; i < int'(NO); i++) dly[i] = int'($urandom_range(0, 3));
      run_op(op, d, int'($urandom_range(0, 3)), lat);
    end

    // Async reset in WAIT_HI.
    inst = 3'b000;
    hang[1] = 1'b1;
    in_opcode = 2'd1;
    in_data = 8'h11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("rst_pre_enable", 32'(op_enable), 32'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {op_enable, out_valid, in_ready}, {3'b000, 1'b0, 1'b1});
    step();
    rst_n = 1'b1;
    hang[1] = 1'b0;
    c0 = en_count;
    c1 = ov_count;
    repeat (20) step();
    chk("rst_no_output", {en_count, ov_count}, {c0, c1});

    // Unit that never answers.
    hang[1] = 1'b1;
    in_opcode = 2'd1;
    in_data = 8'h42;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    n = 0;
    c0 = 0;
    while (n < 100 && !(c0 > 0 && !op_enable[1])) begin
      step();
      if (op_enable[1]) c0++;
      n++;
    end
    chk("tmo_hi_cycles", c0, 32'd32);
    wait_out(100, n);
    chk("tmo_out", {out_valid, out_err, out_opcode, out_result}, {1'b1, 1'b1, 2'd1, 4'h0});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`else
    repeat (1000) step();
    chk("no_tmo_wait", {op_enable, out_valid, in_ready}, {3'b010, 1'b0, 1'b0});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`endif
    hang[1] = 1'b0;
    step();
    chk("final_idle", {in_ready, out_valid}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
